mc_seq: RTL and testbench

//  Machine-cycle sequencer for the 4-bit microprocessor datapath.

---
 rtl/mc_seq.sv | 136 +++++++++++++
 tb/tb_mc_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mc_seq.sv
// rtl/mc_seq.sv - machine-cycle sequencer for the 4-bit microprocessor datapath
//
// Orders the load strobes for RI (A_o), RD (B_o), ACT (C_o), ACC (D_o) and PC (E_o).
// Also provides the program-memory req/ack handshake, HALT handling, an ack timeout
// and a retired-instruction counter. Moore machine: every output is decoded from the
// state register or is itself a register.
//
// Optional feature macro: MC_SEQ_STEP_EN (single-step start from IDLE via step_i).
//
// Ports:
//   clk         in   rising-edge system clock
//   rst_i       in   asynchronous active-low reset
//   run_i       in   level, fetch/execute continuously
//   step_i      in   one-cycle pulse, run one instruction (MC_SEQ_STEP_EN only)
//   mem_ack_i   in   program memory acknowledge
//   need_op_i   in   decoder: current instruction takes a data operand
//   halt_ins_i  in   decoder: current instruction is HALT
//   mem_req_o   out  program memory request
//   mem_sel_o   out  0 = instruction fetch, 1 = operand fetch
//   A_o..E_o    out  one-cycle load strobes for RI, RD, ACT, ACC, PC
//   Q_o         out  current state code
//   halted_o    out  machine halted
//   err_o       out  ack timeout occurred (sticky until reset)
//   ret_cnt_o   out  retired instructions, modulo 2^CNT_W

module mc_seq #(
   parameter int ACK_TIMEOUT = 15,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             step_i,
   input  logic             mem_ack_i,
   input  logic             need_op_i,
   input  logic             halt_ins_i,
   output logic             mem_req_o,
   output logic             mem_sel_o,
   output logic             A_o,
   output logic             B_o,
   output logic             C_o,
   output logic             D_o,
   output logic             E_o,
   output logic [3:0]       Q_o,
   output logic             halted_o,
   output logic             err_o,
   output logic [CNT_W-1:0] ret_cnt_o
);

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FREQ  = 4'd1,
      S_LDRI  = 4'd2,
      S_DEC   = 4'd3,
      S_OREQ  = 4'd4,
      S_LDRD  = 4'd5,
      S_EXEC  = 4'd6,
      S_WB    = 4'd7,
      S_PCINC = 4'd8,
      S_HALT  = 4'd9,
      S_ERR   = 4'd10
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [7:0]       timer;
   logic             go;
   logic             in_req;
   logic             timeout_hit;

`ifdef MC_SEQ_STEP_EN
   // A step pulse only matters in IDLE; run_i alone keeps the machine going after PCINC.
   assign go = run_i | step_i;
`else
   logic unused_step;
   assign unused_step = step_i;
   assign go          = run_i;
`endif

   assign in_req      = (state == S_FREQ) || (state == S_OREQ);
   assign timeout_hit = (timer == 8'(ACK_TIMEOUT));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (go) state_nx = S_FREQ;
         // ack takes priority over the timeout in the same cycle
         S_FREQ:  if (mem_ack_i) state_nx = S_LDRI;
                  else if (timeout_hit) state_nx = S_ERR;
         S_LDRI:  state_nx = S_DEC;
         S_DEC:   if (halt_ins_i) state_nx = S_HALT;
                  else if (need_op_i) state_nx = S_OREQ;
                  else state_nx = S_EXEC;
         S_OREQ:  if (mem_ack_i) state_nx = S_LDRD;
                  else if (timeout_hit) state_nx = S_ERR;
         S_LDRD:  state_nx = S_EXEC;
         S_EXEC:  state_nx = S_WB;
         S_WB:    state_nx = S_PCINC;
         S_PCINC: state_nx = run_i ? S_FREQ : S_IDLE;
         S_HALT:  state_nx = S_HALT;
         S_ERR:   state_nx = S_ERR;
         default: state_nx = S_IDLE;
      endcase
   end

   // Timer is held at zero outside the request states, so it is always zero on entry.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state     <= S_IDLE;
         timer     <= 8'd0;
         ret_cnt_o <= '0;
      end else begin
         state <= state_nx;
         if (in_req) begin
            if (!mem_ack_i) timer <= timer + 8'd1;
         end else begin
            timer <= 8'd0;
         end
         if (state == S_PCINC) ret_cnt_o <= ret_cnt_o + CNT_W'(1);
      end
   end

   always_comb begin
      mem_req_o = in_req;
      mem_sel_o = (state == S_OREQ);
      A_o       = (state == S_LDRI);
      B_o       = (state == S_LDRD);
      C_o       = (state == S_EXEC);
      D_o       = (state == S_WB);
      E_o       = (state == S_LDRD) || (state == S_PCINC);
      halted_o  = (state == S_HALT);
      err_o     = (state == S_ERR);
      Q_o       = state;
   end

endmodule

// File: tb/tb_mc_seq.sv
// tb/tb_mc_seq.sv - directed self-checking bench for mc_seq

module tb_mc_seq;

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic       run_i = 1'b0;
   logic       step_i = 1'b0;
   logic       mem_ack_i = 1'b0;
   logic       need_op_i = 1'b0;
   logic       halt_ins_i = 1'b0;
   logic       mem_req_o, mem_sel_o;
   logic       A_o, B_o, C_o, D_o, E_o;
   logic [3:0] Q_o;
   logic       halted_o, err_o;
   logic [7:0] ret_cnt_o;

   int n_vec  = 0;
   int n_miss = 0;
   int e_cnt  = 0;
   int sel_cnt = 0;

   always #5 clk = ~clk;

   mc_seq #(.ACK_TIMEOUT(3), .CNT_W(8)) dut (
      .clk(clk), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
      .mem_ack_i(mem_ack_i), .need_op_i(need_op_i), .halt_ins_i(halt_ins_i),
      .mem_req_o(mem_req_o), .mem_sel_o(mem_sel_o),
      .A_o(A_o), .B_o(B_o), .C_o(C_o), .D_o(D_o), .E_o(E_o),
      .Q_o(Q_o), .halted_o(halted_o), .err_o(err_o), .ret_cnt_o(ret_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected {A,B,C,D,E} for each state code
   function automatic logic [4:0] strb_of(input logic [3:0] q);
      case (q)
         4'd2:    return 5'b10000;
         4'd5:    return 5'b01001;
         4'd6:    return 5'b00100;
         4'd7:    return 5'b00010;
         4'd8:    return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk(input logic [3:0] q);
      tick();
      chk("state", Q_o, q);
      chk("strobes", {A_o, B_o, C_o, D_o, E_o}, strb_of(q));
      chk("mem_req", mem_req_o, (q == 4'd1 || q == 4'd4));
      e_cnt   += E_o;
      sel_cnt += mem_sel_o;
   endtask

   task automatic async_reset();
      #2 rst_i = 1'b0;
      #1;
      chk("rst_state", Q_o, 4'd0);
      chk("rst_strobes", {A_o, B_o, C_o, D_o, E_o}, 5'b0);
      chk("rst_cnt", ret_cnt_o, 8'd0);
      chk("rst_halt_err", {halted_o, err_o, mem_req_o, mem_sel_o}, 4'b0);
      rst_i = 1'b1;
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("reset_state", Q_o, 4'd0);
      chk("reset_outs", {mem_req_o, mem_sel_o, halted_o, err_o, A_o, B_o, C_o, D_o, E_o}, 9'b0);
      chk("reset_cnt", ret_cnt_o, 8'd0);
      rst_i = 1'b1;
      step_chk(4'd0);

      // zero-wait fetch, no operand
      run_i = 1'b1; mem_ack_i = 1'b1;
      step_chk(4'd1); step_chk(4'd2); step_chk(4'd3);
      step_chk(4'd6); step_chk(4'd7); step_chk(4'd8);
      chk("cnt_in_pcinc", ret_cnt_o, 8'd0);
      step_chk(4'd1);
      chk("cnt_after_1", ret_cnt_o, 8'd1);

      // operand path with two ack wait cycles in OREQ
      need_op_i = 1'b1; e_cnt = 0; sel_cnt = 0;
      step_chk(4'd2); step_chk(4'd3);
      mem_ack_i = 1'b0;
      step_chk(4'd4); step_chk(4'd4); step_chk(4'd4);
      mem_ack_i = 1'b1;
      step_chk(4'd5); step_chk(4'd6); step_chk(4'd7); step_chk(4'd8); step_chk(4'd1);
      chk("e_per_op_instr", e_cnt, 2);
      chk("sel_cycles", sel_cnt, 3);
      chk("cnt_after_2", ret_cnt_o, 8'd2);

      // ack arrives exactly when timer == ACK_TIMEOUT: no error
      need_op_i = 1'b0; mem_ack_i = 1'b0;
      step_chk(4'd1); step_chk(4'd1); step_chk(4'd1);
      mem_ack_i = 1'b1;
      step_chk(4'd2);
      chk("no_err_edge", err_o, 1'b0);
      step_chk(4'd3); step_chk(4'd6); step_chk(4'd7); step_chk(4'd8); step_chk(4'd1);
      chk("cnt_after_3", ret_cnt_o, 8'd3);

      // HALT: no C/D/E, count unchanged, stuck until reset
      step_chk(4'd2);
      halt_ins_i = 1'b1;
      step_chk(4'd3);
      step_chk(4'd9);
      chk("halted", halted_o, 1'b1);
      step_chk(4'd9); step_chk(4'd9); step_chk(4'd9);
      chk("cnt_halt", ret_cnt_o, 8'd3);
      async_reset();

      // reset in the middle of EXEC
      halt_ins_i = 1'b0;
      step_chk(4'd1); step_chk(4'd2); step_chk(4'd3); step_chk(4'd6);
      async_reset();

      // ack timeout with ack held low
      mem_ack_i = 1'b0;
      step_chk(4'd1); step_chk(4'd1); step_chk(4'd1); step_chk(4'd1);
      step_chk(4'd10);
      chk("err", err_o, 1'b1);
      mem_ack_i = 1'b1;
      step_chk(4'd10); step_chk(4'd10);
      chk("err_sticky", err_o, 1'b1);
      async_reset();

      // retired counter wrap
      step_chk(4'd1);
      repeat (255 * 6) tick();
      chk("wrap_state", Q_o, 4'd1);
      chk("cnt_255", ret_cnt_o, 8'd255);
      repeat (6) tick();
      chk("cnt_wrap", ret_cnt_o, 8'd0);

      // run_i falls mid-instruction: completes, then IDLE
      step_chk(4'd2);
      run_i = 1'b0;
      step_chk(4'd3); step_chk(4'd6); step_chk(4'd7); step_chk(4'd8); step_chk(4'd0);
      chk("cnt_run_drop", ret_cnt_o, 8'd1);
      step_chk(4'd0);

      // single step pulse from IDLE
      step_i = 1'b1;
      tick();
      step_i = 1'b0;
`ifdef MC_SEQ_STEP_EN
      chk("step_start", Q_o, 4'd1);
      repeat (6) tick();
      chk("step_end", Q_o, 4'd0);
      chk("step_cnt", ret_cnt_o, 8'd2);
`else
      chk("step_ignored", Q_o, 4'd0);
      repeat (6) tick();
      chk("step_end", Q_o, 4'd0);
      chk("step_cnt", ret_cnt_o, 8'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
